// File: rtl/spongent_perm_iter.sv
// Iterated SPONGENT permutation: one round per clock, or two per clock when
// SPONGENT_UNROLL2_EN is defined. The port list is identical in both builds.
module spongent_perm_iter #(
   parameter int unsigned      B        = 264,
   parameter int unsigned      ROUNDS   = 140,
   parameter int unsigned      CNT_W    = 8,
   parameter logic [CNT_W-1:0] CNT_INIT = CNT_W'(8'hC7),
   parameter logic [CNT_W-1:0] CNT_POLY = CNT_W'(8'h8E)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [B-1:0]     state_in,
   output logic             busy,
   output logic             done,
   output logic [B-1:0]     state_out,
   output logic [CNT_W-1:0] cnt_out
);

   localparam int unsigned RW = $clog2(ROUNDS + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [B-1:0]     work_q, work_d;
   logic [B-1:0]     out_q, out_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RW-1:0]    rnd_q, rnd_d;

   logic [B-1:0]     run_s;
   logic [CNT_W-1:0] run_c;
   logic [RW-1:0]    run_r;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hE;  4'h1: y = 4'hD;  4'h2: y = 4'hB;  4'h3: y = 4'h0;
         4'h4: y = 4'h2;  4'h5: y = 4'h1;  4'h6: y = 4'h4;  4'h7: y = 4'hF;
         4'h8: y = 4'h7;  4'h9: y = 4'hA;  4'hA: y = 4'h8;  4'hB: y = 4'h5;
         4'hC: y = 4'h9;  4'hD: y = 4'hC;  4'hE: y = 4'h3;  default: y = 4'h6;
      endcase
      return y;
   endfunction

   function automatic logic [CNT_W-1:0] lfsr_step(input logic [CNT_W-1:0] c);
      return {c[CNT_W-2:0], ^(c & CNT_POLY)};
   endfunction

   function automatic logic [B-1:0] round_f(input logic [B-1:0] s, input logic [CNT_W-1:0] c);
      logic [B-1:0] t;
      logic [B-1:0] p;
      t = s;
      // counter into the low bits, bit-reversed counter into the top bits
      for (int i = 0; i < CNT_W; i++) begin
         t[i]       = t[i] ^ c[i];
         t[B-1-i]   = t[B-1-i] ^ c[i];
      end
      for (int n = 0; n < B / 4; n++) begin
         t[4*n +: 4] = sbox(t[4*n +: 4]);
      end
      p = '0;
      for (int j = 0; j < B - 1; j++) begin
         p[(j * (B / 4)) % (B - 1)] = t[j];
      end
      p[B-1] = t[B-1];
      return p;
   endfunction

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      rnd_d   = rnd_q;

      run_s = round_f(work_q, cnt_q);
      run_c = lfsr_step(cnt_q);
      run_r = rnd_q + RW'(1);
`ifdef SPONGENT_UNROLL2_EN
      // second round only while at least two remain, so odd counts end on a single round
      if ((ROUNDS - 32'(rnd_q)) >= 32'd2) begin
         run_s = round_f(run_s, run_c);
         run_c = lfsr_step(run_c);
         run_r = rnd_q + RW'(2);
      end
`endif

      unique case (state_q)
         StIdle: begin
            cnt_d = CNT_INIT;
            if (start) begin
               state_d = StRun;
               work_d  = state_in;
               rnd_d   = '0;
            end
         end
         StRun: begin
            work_d = run_s;
            cnt_d  = run_c;
            rnd_d  = run_r;
            if (run_r == RW'(ROUNDS)) begin
               state_d = StDone;
               out_d   = run_s;
            end
         end
         StDone: begin
            state_d = StIdle;
            cnt_d   = CNT_INIT;
            rnd_d   = '0;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = CNT_INIT;
            rnd_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         work_q  <= '0;
         out_q   <= '0;
         cnt_q   <= CNT_INIT;
         rnd_q   <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         rnd_q   <= rnd_d;
      end
   end

   assign busy      = (state_q == StRun);
   assign done      = (state_q == StDone);
   assign state_out = out_q;
   assign cnt_out   = cnt_q;

endmodule

// File: tb/tb_spongent_perm_iter.sv
// Scoreboard bench for spongent_perm_iter: three instances (small, default, single-round)
// checked against an independent bit-level permutation model.
module tb_spongent_perm_iter;

   localparam int AB = 88;
   localparam int AR = 45;
   localparam int AW = 6;
   localparam int DB = 264;
   localparam int DR = 140;
   localparam int DW = 8;
`ifdef SPONGENT_UNROLL2_EN
   localparam int ALAT  = (AR + 1) / 2;
   localparam int DLAT  = (DR + 1) / 2;
   localparam int CSTEP = 2;
`else
   localparam int ALAT  = AR;
   localparam int DLAT  = DR;
   localparam int CSTEP = 1;
`endif

   localparam logic [3:0] SBOX [16] = '{4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
                                        4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6};
   localparam logic [5:0] A_CNT_SEQ [6] = '{6'h05, 6'h0A, 6'h14, 6'h29, 6'h13, 6'h27};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          a_start, a_busy, a_done;
   logic [AB-1:0] a_in, a_out;
   logic [AW-1:0] a_cnt;
   logic          d_start, d_busy, d_done;
   logic [DB-1:0] d_in, d_out;
   logic [DW-1:0] d_cnt;
   logic          s_start, s_busy, s_done;
   logic [AB-1:0] s_in, s_out;
   logic [AW-1:0] s_cnt;

   int checks = 0;
   int errors = 0;
   logic [263:0] sb [$];

   spongent_perm_iter #(.B(AB), .ROUNDS(AR), .CNT_W(AW), .CNT_INIT(6'h05), .CNT_POLY(6'h30))
   u_a (.clk(clk), .rst(rst), .start(a_start), .state_in(a_in), .busy(a_busy), .done(a_done),
        .state_out(a_out), .cnt_out(a_cnt));

   spongent_perm_iter u_d (.clk(clk), .rst(rst), .start(d_start), .state_in(d_in), .busy(d_busy),
                           .done(d_done), .state_out(d_out), .cnt_out(d_cnt));

   spongent_perm_iter #(.B(AB), .ROUNDS(1), .CNT_W(AW), .CNT_INIT(6'h05), .CNT_POLY(6'h30))
   u_s (.clk(clk), .rst(rst), .start(s_start), .state_in(s_in), .busy(s_busy), .done(s_done),
        .state_out(s_out), .cnt_out(s_cnt));

   function automatic logic [263:0] ref_perm(input logic [263:0] s_in, input int b,
                                             input int rounds, input int cw,
                                             input logic [15:0] init, input logic [15:0] poly);
      logic [263:0] s, t;
      logic [15:0]  c, mask;
      logic         fb;
      s    = s_in;
      c    = init;
      mask = 16'((32'd1 << cw) - 1);
      for (int r = 0; r < rounds; r++) begin
         for (int i = 0; i < cw; i++) begin
            s[i]       = s[i] ^ c[i];
            s[b-1-i]   = s[b-1-i] ^ c[cw-1-(cw-1-i)];
         end
         for (int n = 0; n < b / 4; n++) s[4*n +: 4] = SBOX[s[4*n +: 4]];
         t = '0;
         for (int j = 0; j < b - 1; j++) t[(j * b / 4) % (b - 1)] = s[j];
         t[b-1] = s[b-1];
         s  = t;
         fb = ^(c & poly & mask);
         c  = ((c << 1) | {15'd0, fb}) & mask;
      end
      return s;
   endfunction

   function automatic logic [263:0] rand_vec();
      logic [287:0] v;
      for (int i = 0; i < 9; i++) v[32*i +: 32] = $urandom;
      return v[263:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_start = 1'b0; d_start = 1'b0; s_start = 1'b0;
      a_in = '0; d_in = '0; s_in = '0;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
      checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", a_done); end
      checks++; if (a_out !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", a_out); end
      checks++; if (a_cnt !== 6'h05) begin errors++; $display("FAIL reset_cnt: got %h want 05", a_cnt); end
      checks++; if (d_out !== '0) begin errors++; $display("FAIL reset_out_d: got %h want 0", d_out); end
      checks++; if (d_cnt !== 8'hC7) begin errors++; $display("FAIL reset_cnt_d: got %h want c7", d_cnt); end
      tick();
      checks++; if (a_cnt !== 6'h05 || a_busy !== 1'b0) begin
         errors++; $display("FAIL idle_hold: got cnt %h busy %b want 05 0", a_cnt, a_busy);
      end
   endtask

   task automatic test_cnt_seq();
      logic [263:0] v, exp;
      int cyc;
      sb.delete();
      v = rand_vec();
      sb.push_back(ref_perm({176'd0, v[87:0]}, AB, AR, AW, 16'h05, 16'h30));
      a_in = v[87:0]; a_start = 1'b1;
      tick();
      a_start = 1'b0; a_in = '0;
      cyc = 0;
      while (a_done !== 1'b1 && cyc < 400) begin
         if (cyc * CSTEP < 6) begin
            checks++;
            if (a_cnt !== A_CNT_SEQ[cyc*CSTEP]) begin
               errors++; $display("FAIL cnt_seq[%0d]: got %h want %h", cyc, a_cnt, A_CNT_SEQ[cyc*CSTEP]);
            end
         end
         checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL run_busy[%0d]: got %b want 1", cyc, a_busy); end
         tick();
         cyc++;
      end
      checks++; if (cyc != ALAT) begin errors++; $display("FAIL latency_a: got %0d want %0d", cyc, ALAT); end
      exp = (sb.size() > 0) ? sb.pop_front() : '0;
      checks++; if (a_out !== exp[87:0]) begin errors++; $display("FAIL result_a: got %h want %h", a_out, exp[87:0]); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %b want 0", a_busy); end
      tick();
      checks++; if (a_done !== 1'b0 || a_cnt !== 6'h05) begin
         errors++; $display("FAIL done_pulse: got done %b cnt %h want 0 05", a_done, a_cnt);
      end
   endtask

   task automatic test_random();
      logic [263:0] v, exp;
      int cyc;
      sb.delete();
      for (int it = 0; it < 100; it++) begin
         v = rand_vec();
         sb.push_back(ref_perm(v, DB, DR, DW, 16'hC7, 16'h8E));
         d_in = v; d_start = 1'b1;
         tick();
         d_start = 1'b0;
         cyc = 0;
         while (d_done !== 1'b1 && cyc < DLAT + 20) begin
            tick();
            cyc++;
         end
         checks++; if (cyc != DLAT) begin errors++; $display("FAIL latency_d[%0d]: got %0d want %0d", it, cyc, DLAT); end
         exp = (sb.size() > 0) ? sb.pop_front() : '0;
         checks++; if (d_out !== exp) begin errors++; $display("FAIL result_d[%0d]: got %h want %h", it, d_out, exp); end
         tick();
         checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL pulse_d[%0d]: got %b want 0", it, d_done); end
      end
   endtask

   task automatic test_start_held();
      logic [263:0] v, exp;
      logic [AB-1:0] held;
      logic have_held;
      int calls, last_done;
      sb.delete();
      a_start = 1'b1; calls = 0; have_held = 1'b0; last_done = -1; held = '0;
      for (int cyc = 0; cyc < 3 * (ALAT + 2) + 10 && calls < 3; cyc++) begin
         v = rand_vec();
         a_in = v[87:0];
         // only an idle instance samples state_in at the coming edge
         if (a_busy === 1'b0 && a_done === 1'b0)
            sb.push_back(ref_perm({176'd0, v[87:0]}, AB, AR, AW, 16'h05, 16'h30));
         tick();
         if (a_done === 1'b1) begin
            exp = (sb.size() > 0) ? sb.pop_front() : '0;
            checks++; if (a_out !== exp[87:0]) begin errors++; $display("FAIL held_result[%0d]: got %h want %h", calls, a_out, exp[87:0]); end
            if (last_done >= 0) begin
               checks++; if (cyc - last_done != ALAT + 2) begin
                  errors++; $display("FAIL held_gap: got %0d want %0d", cyc - last_done, ALAT + 2);
               end
            end
            last_done = cyc; held = a_out; have_held = 1'b1; calls++;
         end else if (have_held) begin
            checks++; if (a_out !== held) begin errors++; $display("FAIL held_stable: got %h want %h", a_out, held); end
         end
      end
      a_start = 1'b0;
      checks++; if (calls != 3) begin errors++; $display("FAIL held_calls: got %0d want 3", calls); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL held_queue: got %0d left want 0", sb.size()); end
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      logic [263:0] v, exp;
      int cyc, seen;
      sb.delete();
      v = rand_vec();
      a_in = v[87:0]; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      repeat (10) tick();
      rst = 1'b1; a_start = 1'b1;
      tick();
      rst = 1'b0; a_start = 1'b0;
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", a_busy); end
      checks++; if (a_out !== '0) begin errors++; $display("FAIL abort_out: got %h want 0", a_out); end
      checks++; if (a_cnt !== 6'h05) begin errors++; $display("FAIL abort_cnt: got %h want 05", a_cnt); end
      seen = 0;
      for (int i = 0; i < ALAT + 5; i++) begin
         if (a_done !== 1'b0 || a_busy !== 1'b0) seen++;
         tick();
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", seen); end
      v = rand_vec();
      sb.push_back(ref_perm({176'd0, v[87:0]}, AB, AR, AW, 16'h05, 16'h30));
      a_in = v[87:0]; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      cyc = 0;
      while (a_done !== 1'b1 && cyc < ALAT + 20) begin
         tick();
         cyc++;
      end
      checks++; if (cyc != ALAT) begin errors++; $display("FAIL restart_latency: got %0d want %0d", cyc, ALAT); end
      exp = (sb.size() > 0) ? sb.pop_front() : '0;
      checks++; if (a_out !== exp[87:0]) begin errors++; $display("FAIL restart_result: got %h want %h", a_out, exp[87:0]); end
      tick();
   endtask

   task automatic test_single_round();
      logic [263:0] exp;
      int cyc;
      sb.delete();
      sb.push_back(ref_perm('0, AB, 1, AW, 16'h05, 16'h30));
      s_in = '0; s_start = 1'b1;
      tick();
      s_start = 1'b0;
      checks++; if (s_busy !== 1'b1 || s_cnt !== 6'h05) begin
         errors++; $display("FAIL single_run: got busy %b cnt %h want 1 05", s_busy, s_cnt);
      end
      cyc = 0;
      while (s_done !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      checks++; if (cyc != 1) begin errors++; $display("FAIL single_latency: got %0d want 1", cyc); end
      exp = (sb.size() > 0) ? sb.pop_front() : '0;
      checks++; if (s_out !== exp[87:0]) begin errors++; $display("FAIL single_result: got %h want %h", s_out, exp[87:0]); end
      tick();
      checks++; if (s_done !== 1'b0 || s_busy !== 1'b0) begin
         errors++; $display("FAIL single_idle: got done %b busy %b want 0 0", s_done, s_busy);
      end
   endtask

   initial begin
      test_reset();
      test_cnt_seq();
      test_random();
      test_start_held();
      test_reset_mid();
      test_single_round();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spongent_perm_iter.md
SPONGENT_PERM_ITER -- requirements
Module: spongent_perm_iter

Interface
REQ-001 Parameter B, default 264: state width in bits; multiple of 8, at least 16.
REQ-002 Parameter ROUNDS, default 140: rounds per permutation call, range 1..1023.
REQ-003 Parameter CNT_W, default 8: round-counter LFSR width, range 4..16, CNT_W <= B/2.
REQ-004 Parameter CNT_INIT, default 8'hC7: LFSR value used in round 0; must be nonzero.
REQ-005 Parameter CNT_POLY, default 8'h8E: feedback tap mask; feedback bit = XOR-reduce(cnt & CNT_POLY).
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 start  in  1  one-cycle request to begin a permutation on state_in.
REQ-009 state_in  in  B  permutation input; sampled only in the cycle start is accepted.
REQ-010 busy  out  1  high while rounds are executing.
REQ-011 done  out  1  one-cycle pulse when state_out becomes valid.
REQ-012 state_out  out  B  permutation result; held stable from done until the next accepted start.
REQ-013 cnt_out  out  CNT_W  LFSR value to be applied in the next round (debug/observability).

Function
REQ-014 Round r on state S: S[CNT_W-1:0] ^= cnt; S[B-1 -: CNT_W] ^= bitrev(cnt); apply S-box to every nibble; apply pLayer.
REQ-015 S-box: 0..F -> E,D,B,0,2,1,4,F,7,A,8,5,9,C,3,6.
REQ-016 pLayer: bit j moves to position (j*B/4) mod (B-1) for j < B-1; bit B-1 stays in place.
REQ-017 LFSR step: cnt_next = {cnt[CNT_W-2:0], XOR-reduce(cnt & CNT_POLY)}.
REQ-018 States: IDLE, RUN, DONE.
REQ-019 IDLE with start=1 -> RUN; load state_in into the working register; load CNT_INIT into cnt; clear the round counter.
REQ-020 RUN executes one round per cycle, advances cnt, and increments the round counter.
REQ-021 RUN exits to DONE in the cycle in which the ROUNDS-th round is registered.
REQ-022 DONE lasts one cycle: done=1, state_out updated, busy=0, then -> IDLE.
REQ-023 Latency: start accepted at edge k -> done high in the cycle following edge k+ROUNDS.
REQ-024 start while in RUN or DONE is ignored: no restart, no queuing, state_in not sampled.
REQ-025 busy = 1 exactly in RUN.
REQ-026 state_out changes only on entry to DONE.
REQ-027 cnt_out holds CNT_INIT while in IDLE.
REQ-028 The round counter is ceil(log2(ROUNDS+1)) bits wide and never wraps within a call.
REQ-029 ROUNDS=1: a single RUN cycle, then DONE.

Reset
REQ-030 rst=1 at a clock edge forces IDLE, busy=0, done=0, state_out=0, cnt=CNT_INIT, and clears the round counter; this holds in any state.
REQ-031 Reset during RUN aborts the call with no done pulse; the old state_out is not preserved.
REQ-032 rst has priority over start in the same cycle.

Configuration
REQ-033 Macro SPONGENT_UNROLL2_EN defined: two rounds per RUN cycle (cnt advances twice), latency ceil(ROUNDS/2) cycles.
REQ-034 With SPONGENT_UNROLL2_EN and odd ROUNDS, the final RUN cycle executes exactly one round.
REQ-035 Macro undefined: one round per cycle as in REQ-020; the port list is identical in both builds.

Verification
REQ-036 B=88, ROUNDS=45, CNT_W=6, CNT_INIT=6'h05, CNT_POLY=6'h30; pulse start -> cnt_out over successive RUN cycles = 05,0A,14,29,13,27; done exactly 45 cycles after accept.
REQ-037 Default parameters, 100 random state_in values -> state_out matches the bit-exact C reference model for each; done pulses once per call.
REQ-038 start held high continuously -> exactly one call per IDLE visit; no start is sampled while busy=1; state_out stable between done pulses.
REQ-039 rst asserted at round 10 of a call -> next cycle busy=0, state_out=0, cnt_out=CNT_INIT, no done pulse; a fresh start then completes normally.
REQ-040 With SPONGENT_UNROLL2_EN, B=88, ROUNDS=45 -> done 23 cycles after accept; state_out equals the non-unrolled result for the same input.
REQ-041 ROUNDS=1, state_in=0 -> done 1 cycle after accept; state_out equals the reference model's single-round result.
